// File: rtl/ro_pkg.sv
// Shared constants and helpers for the readout slot scheduler.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ro_pkg;

    localparam int N_CH_DEF  = 8;
    localparam int CNT_W_DEF = 19;
    localparam int MAX_W     = 32;

    // Binary to reflected gray code.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] v);
        return v ^ (v >> 1);
    endfunction

    // Trailing-zero count over the low w bits of v; w-1 when those bits are all
    // zero, so the counter wrap lands on the top gray bit like a normal carry.
    function automatic int ctz(input logic [MAX_W-1:0] v, input int w);
        int r;
        r = w - 1;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (i < w && v[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ro_evt_capture.sv
// Per-channel event capture: rising-edge detect, one-deep pending slot, sticky overrun.
// Latency: an edge is pending one cycle after it is seen; it is never passed through.
// Backpressure: none; an edge arriving while a pending event waits is dropped and flagged.
//
// Ports: clk_master/rstb clock and async reset; in_eve/in_pol_eve channel input;
// serve = this channel owns the slot this cycle; clr_ovr clears ovr;
// pending/pol hold the waiting event, ovr is the sticky overrun flag.
module ro_evt_capture (
    input  logic clk_master,
    input  logic rstb,
    input  logic in_eve,
    input  logic in_pol_eve,
    input  logic serve,
    input  logic clr_ovr,
    output logic pending,
    output logic pol,
    output logic ovr
);

    logic prev_eve;
    logic rise;

    assign rise = in_eve & ~prev_eve;

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            prev_eve <= 1'b0;
            pending  <= 1'b0;
            pol      <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            prev_eve <= in_eve;

            // On a service cycle the top samples the old pending/pol before this
            // edge, so a coincident new event simply becomes the next pending one.
            if (serve) begin
                pending <= rise;
                if (rise) begin
                    pol <= in_pol_eve;
                end
            end else if (rise && !pending) begin
                pending <= 1'b1;
                pol     <= in_pol_eve;
            end

            // A fresh overrun beats a simultaneous clear.
            if (rise && pending && !serve) begin
                ovr <= 1'b1;
            end else if (clr_ovr) begin
                ovr <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ro_slot_scheduler.sv
// Gray-counter TDM scheduler sharing one event/polarity line pair among N_CH channels.
// Latency: slot outputs update on the same edge as gray; no further pipeline.
// Backpressure: en=0 freezes the counter and idles the outputs; capture keeps running.
//
// Ports: clk_master, rstb (async active-low), en, in_eve/in_pol_eve per channel,
// clr_ovr; outputs gray, out_mux_eve, out_mux_pol_eve, slot_ch, slot_valid,
// frame_sync, ovr.
module ro_slot_scheduler
    import ro_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk_master,
    input  logic             rstb,
    input  logic             en,
    input  logic [N_CH-1:0]  in_eve,
    input  logic [N_CH-1:0]  in_pol_eve,
    input  logic             clr_ovr,
    output logic [CNT_W-1:0] gray,
    output logic             out_mux_eve,
    output logic             out_mux_pol_eve,
    output logic [SEL_W-1:0] slot_ch,
    output logic             slot_valid,
    output logic             frame_sync,
    output logic [N_CH-1:0]  ovr
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt;
    int               s;
    logic             chan_slot;
    logic [SEL_W-1:0] sel;
    logic [N_CH-1:0]  serve;
    logic [N_CH-1:0]  pending;
    logic [N_CH-1:0]  pol;

    // The bit that toggles in gray on cnt->nxt is the lowest set bit of nxt.
    always_comb begin
        nxt       = cnt + CNT_W'(1);
        s         = ctz(MAX_W'(nxt), CNT_W);
        chan_slot = (s < N_CH);
        sel       = SEL_W'(s);
        serve     = '0;
        if (en && chan_slot) begin
            serve = N_CH'(1) << sel;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_cap
        ro_evt_capture u_cap (
            .clk_master (clk_master),
            .rstb       (rstb),
            .in_eve     (in_eve[i]),
            .in_pol_eve (in_pol_eve[i]),
            .serve      (serve[i]),
            .clr_ovr    (clr_ovr),
            .pending    (pending[i]),
            .pol        (pol[i]),
            .ovr        (ovr[i])
        );
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            cnt             <= '0;
            gray            <= '0;
            out_mux_eve     <= 1'b0;
            out_mux_pol_eve <= 1'b0;
            slot_ch         <= '0;
            slot_valid      <= 1'b0;
            frame_sync      <= 1'b0;
        end else if (en) begin
            cnt  <= nxt;
            gray <= CNT_W'(bin2gray(MAX_W'(nxt)));
            if (chan_slot) begin
                slot_ch         <= sel;
                slot_valid      <= 1'b1;
                frame_sync      <= 1'b0;
                out_mux_eve     <= pending[sel];
                out_mux_pol_eve <= pending[sel] & pol[sel];
            end else begin
                slot_ch         <= '0;
                slot_valid      <= 1'b0;
                frame_sync      <= 1'b1;
                out_mux_eve     <= 1'b0;
                out_mux_pol_eve <= 1'b0;
            end
        end else begin
            slot_valid      <= 1'b0;
            frame_sync      <= 1'b0;
            out_mux_eve     <= 1'b0;
            out_mux_pol_eve <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ro_slot_scheduler.sv
module tb_ro_slot_scheduler;

    logic        clk;
    logic        rstb;
    logic        en;
    logic [7:0]  in_eve;
    logic [7:0]  in_pol_eve;
    logic        clr_ovr;
    logic [18:0] gray;
    logic        out_mux_eve;
    logic        out_mux_pol_eve;
    logic [2:0]  slot_ch;
    logic        slot_valid;
    logic        frame_sync;
    logic [7:0]  ovr;

    // Small build (3 channels, 4-bit counter) for the wrap check.
    logic        en2;
    logic [2:0]  in_eve2;
    logic [2:0]  in_pol_eve2;
    logic        clr_ovr2;
    logic [3:0]  gray2;
    logic        out_mux_eve2;
    logic        out_mux_pol_eve2;
    logic [1:0]  slot_ch2;
    logic        slot_valid2;
    logic        frame_sync2;
    logic [2:0]  ovr2;

    int checks;
    int errors;
    int cnt_tb;

    ro_slot_scheduler #(.N_CH(8), .CNT_W(19), .SEL_W(3)) dut (
        .clk_master      (clk),
        .rstb            (rstb),
        .en              (en),
        .in_eve          (in_eve),
        .in_pol_eve      (in_pol_eve),
        .clr_ovr         (clr_ovr),
        .gray            (gray),
        .out_mux_eve     (out_mux_eve),
        .out_mux_pol_eve (out_mux_pol_eve),
        .slot_ch         (slot_ch),
        .slot_valid      (slot_valid),
        .frame_sync      (frame_sync),
        .ovr             (ovr)
    );

    ro_slot_scheduler #(.N_CH(3), .CNT_W(4), .SEL_W(2)) dut2 (
        .clk_master      (clk),
        .rstb            (rstb),
        .en              (en2),
        .in_eve          (in_eve2),
        .in_pol_eve      (in_pol_eve2),
        .clr_ovr         (clr_ovr2),
        .gray            (gray2),
        .out_mux_eve     (out_mux_eve2),
        .out_mux_pol_eve (out_mux_pol_eve2),
        .slot_ch         (slot_ch2),
        .slot_valid      (slot_valid2),
        .frame_sync      (frame_sync2),
        .ovr             (ovr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int tz(input int v);
        int k;
        k = 0;
        while (k < 19 && v[k] == 1'b0) k++;
        if (k == 19) k = 18;
        return k;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (en) cnt_tb++;
    endtask

    task automatic run_to(input int target);
        while (cnt_tb < target) step();
    endtask

    task automatic do_reset();
        in_eve = '0; in_pol_eve = '0; clr_ovr = 1'b0; en = 1'b1;
        rstb = 1'b0;
        step();
        step();
        rstb = 1'b1;
        cnt_tb = 0;
    endtask

    task automatic test_reset();
        rstb = 1'b0; en = 1'b1; en2 = 1'b1;
        in_eve = '0; in_pol_eve = '0; clr_ovr = 1'b0;
        in_eve2 = '0; in_pol_eve2 = '0; clr_ovr2 = 1'b0;
        #12;
        checks++;
        if ({gray, out_mux_eve, out_mux_pol_eve, slot_ch, slot_valid, frame_sync, ovr} !== '0) begin
            errors++;
            $display("FAIL reset_main: gray=%h eve=%b pol=%b ch=%0d vld=%b fs=%b ovr=%h want all zero",
                     gray, out_mux_eve, out_mux_pol_eve, slot_ch, slot_valid, frame_sync, ovr);
        end
        checks++;
        if ({gray2, slot_valid2, frame_sync2, ovr2} !== '0) begin
            errors++;
            $display("FAIL reset_small: gray2=%h vld2=%b fs2=%b ovr2=%h want all zero",
                     gray2, slot_valid2, frame_sync2, ovr2);
        end
    endtask

    task automatic test_slot_sequence();
        int es;
        do_reset();
        for (int n = 1; n <= 256; n++) begin
            step();
            es = tz(n);
            checks++;
            if (gray !== 19'(n ^ (n >> 1)) || slot_valid !== (es < 8) || frame_sync !== (es >= 8) ||
                slot_ch !== ((es < 8) ? 3'(es) : 3'd0) || out_mux_eve !== 1'b0) begin
                errors++;
                $display("FAIL slot_seq n=%0d: gray=%h vld=%b fs=%b ch=%0d eve=%b want gray=%h slot=%0d",
                         n, gray, slot_valid, frame_sync, slot_ch, out_mux_eve, n ^ (n >> 1), es);
            end
        end
        checks++;
        if (frame_sync !== 1'b1 || slot_valid !== 1'b0 || gray !== 19'h180) begin
            errors++;
            $display("FAIL frame_256: fs=%b vld=%b gray=%h want fs=1 vld=0 gray=180",
                     frame_sync, slot_valid, gray);
        end
    endtask

    task automatic test_event_ch0();
        do_reset();
        run_to(4);
        in_eve[0] = 1'b1; in_pol_eve[0] = 1'b1;
        step();
        in_eve[0] = 1'b0; in_pol_eve[0] = 1'b0;
        checks++;
        if (slot_ch !== 3'd0 || slot_valid !== 1'b1 || out_mux_eve !== 1'b0) begin
            errors++;
            $display("FAIL ch0_no_passthru: ch=%0d vld=%b eve=%b want ch=0 vld=1 eve=0",
                     slot_ch, slot_valid, out_mux_eve);
        end
        run_to(7);
        checks++;
        if (slot_ch !== 3'd0 || out_mux_eve !== 1'b1 || out_mux_pol_eve !== 1'b1) begin
            errors++;
            $display("FAIL ch0_out: ch=%0d eve=%b pol=%b want ch=0 eve=1 pol=1",
                     slot_ch, out_mux_eve, out_mux_pol_eve);
        end
        run_to(9);
        checks++;
        if (slot_ch !== 3'd0 || out_mux_eve !== 1'b0) begin
            errors++;
            $display("FAIL ch0_cleared: ch=%0d eve=%b want ch=0 eve=0", slot_ch, out_mux_eve);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        run_to(9);
        in_eve[3] = 1'b1; in_pol_eve[3] = 1'b1;
        step();
        in_eve[3] = 1'b0; in_pol_eve[3] = 1'b0;
        checks++;
        if (ovr !== 8'h00) begin
            errors++;
            $display("FAIL ovr_first: ovr=%h want 00", ovr);
        end
        run_to(19);
        in_eve[3] = 1'b1; in_pol_eve[3] = 1'b0;
        step();
        in_eve[3] = 1'b0;
        checks++;
        if (ovr !== 8'h08) begin
            errors++;
            $display("FAIL ovr_set: ovr=%h want 08", ovr);
        end
        run_to(24);
        checks++;
        if (slot_ch !== 3'd3 || out_mux_eve !== 1'b1 || out_mux_pol_eve !== 1'b1) begin
            errors++;
            $display("FAIL ovr_out: ch=%0d eve=%b pol=%b want ch=3 eve=1 pol=1",
                     slot_ch, out_mux_eve, out_mux_pol_eve);
        end
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        checks++;
        if (ovr !== 8'h00) begin
            errors++;
            $display("FAIL ovr_clear: ovr=%h want 00", ovr);
        end
        in_eve[3] = 1'b1;
        step();
        in_eve[3] = 1'b0;
        step();
        in_eve[3] = 1'b1; clr_ovr = 1'b1;
        step();
        in_eve[3] = 1'b0; clr_ovr = 1'b0;
        checks++;
        if (ovr !== 8'h08) begin
            errors++;
            $display("FAIL ovr_beats_clear: ovr=%h want 08", ovr);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        run_to(2);
        in_eve[1] = 1'b1; in_pol_eve[1] = 1'b0;
        step();
        in_eve[1] = 1'b0;
        run_to(5);
        in_eve[1] = 1'b1; in_pol_eve[1] = 1'b1;
        step();
        in_eve[1] = 1'b0; in_pol_eve[1] = 1'b0;
        checks++;
        if (slot_ch !== 3'd1 || out_mux_eve !== 1'b1 || out_mux_pol_eve !== 1'b0 || ovr !== 8'h00) begin
            errors++;
            $display("FAIL same_old: ch=%0d eve=%b pol=%b ovr=%h want ch=1 eve=1 pol=0 ovr=00",
                     slot_ch, out_mux_eve, out_mux_pol_eve, ovr);
        end
        run_to(10);
        checks++;
        if (slot_ch !== 3'd1 || out_mux_eve !== 1'b1 || out_mux_pol_eve !== 1'b1 || ovr !== 8'h00) begin
            errors++;
            $display("FAIL same_new: ch=%0d eve=%b pol=%b ovr=%h want ch=1 eve=1 pol=1 ovr=00",
                     slot_ch, out_mux_eve, out_mux_pol_eve, ovr);
        end
    endtask

    task automatic test_enable();
        do_reset();
        run_to(3);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin in_eve[2] = 1'b1; in_pol_eve[2] = 1'b1; end
            if (i == 6) begin in_eve[2] = 1'b0; in_pol_eve[2] = 1'b0; end
            step();
            checks++;
            if (gray !== 19'h2 || slot_valid !== 1'b0 || frame_sync !== 1'b0 || out_mux_eve !== 1'b0) begin
                errors++;
                $display("FAIL en_off i=%0d: gray=%h vld=%b fs=%b eve=%b want gray=2 vld=0 fs=0 eve=0",
                         i, gray, slot_valid, frame_sync, out_mux_eve);
            end
        end
        en = 1'b1;
        step();
        checks++;
        if (slot_ch !== 3'd2 || out_mux_eve !== 1'b1 || out_mux_pol_eve !== 1'b1 || gray !== 19'h6) begin
            errors++;
            $display("FAIL en_resume: ch=%0d eve=%b pol=%b gray=%h want ch=2 eve=1 pol=1 gray=6",
                     slot_ch, out_mux_eve, out_mux_pol_eve, gray);
        end
    endtask

    task automatic test_wrap();
        int m;
        logic fs_exp;
        logic [1:0] ch_exp;
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            step();
            m = n % 16;
            fs_exp = (n == 8 || n == 16);
            ch_exp = (n % 2 == 1) ? 2'd0 : (n % 4 == 2) ? 2'd1 : (n % 8 == 4) ? 2'd2 : 2'd0;
            checks++;
            if (gray2 !== 4'(m ^ (m >> 1)) || frame_sync2 !== fs_exp || slot_valid2 !== !fs_exp ||
                slot_ch2 !== ch_exp) begin
                errors++;
                $display("FAIL wrap n=%0d: gray2=%b fs2=%b vld2=%b ch2=%0d want gray2=%b fs2=%b ch2=%0d",
                         n, gray2, frame_sync2, slot_valid2, slot_ch2, 4'(m ^ (m >> 1)), fs_exp, ch_exp);
            end
            if (n == 15) begin
                checks++;
                if (gray2 !== 4'b1000) begin
                    errors++;
                    $display("FAIL wrap_top: gray2=%b want 1000", gray2);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_eve[5] = 1'b1;
        step();
        in_eve[5] = 1'b0;
        step();
        in_eve[5] = 1'b1;
        step();
        in_eve[5] = 1'b0;
        step();
        checks++;
        if (ovr !== 8'h20 || gray !== 19'h6 || slot_ch !== 3'd2 || slot_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_arst: ovr=%h gray=%h ch=%0d vld=%b want ovr=20 gray=6 ch=2 vld=1",
                     ovr, gray, slot_ch, slot_valid);
        end
        #3;
        rstb = 1'b0;
        #1;
        checks++;
        if ({gray, out_mux_eve, out_mux_pol_eve, slot_ch, slot_valid, frame_sync, ovr} !== '0 ||
            gray2 !== 4'h0 || slot_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: gray=%h ch=%0d vld=%b ovr=%h gray2=%h want all zero",
                     gray, slot_ch, slot_valid, ovr, gray2);
        end
        step();
        rstb = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cnt_tb = 0;
        test_reset();
        test_slot_sequence();
        test_event_ch0();
        test_overrun();
        test_same_cycle();
        test_enable();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
